fpdiv: RTL

// - Iterative IEEE-754-style floating-point divider: out = a / b.
// - Companion to the FP multiplier in the core datapath. Same start/ready handshake and same format parameters.
// - Restoring mantissa division at 1 quotient bit per clock; special operands take a 1-cycle fast path.

---
 rtl/fpdiv.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fpdiv.sv
// Iterative floating-point divider: restoring mantissa division, one quotient bit per clock,
// round-to-nearest-even with flush-to-zero. Special operands finish in a single busy cycle.
module fpdiv #(
  parameter int unsigned LOG_BIT = 5,
  parameter int unsigned EXP_BIT = 8,
  parameter int unsigned N_BIT   = 1 << LOG_BIT,
  parameter int unsigned MAN_BIT = N_BIT - EXP_BIT - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  output logic [N_BIT-1:0] out,
  output logic             ready
);

  localparam int unsigned QB   = MAN_BIT + 3;
  localparam int unsigned RW   = MAN_BIT + 2;
  localparam int unsigned EW   = EXP_BIT + 2;
  localparam int unsigned CW   = $clog2(QB);
  localparam int          BIAS = (1 << (EXP_BIT - 1)) - 1;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_BIT) - 1);

  typedef enum logic [1:0] {StIdle, StSpec, StDiv, StRnd} state_e;

  state_e                  state_q;
  logic [RW-1:0]           r_q;
  logic [MAN_BIT:0]        d_q;
  logic [QB-1:0]           q_q;
  logic [CW-1:0]           cnt_q;
  logic signed [EW-1:0]    e_q;
  logic                    sgn_q;
  logic [N_BIT-1:0]        spec_q;

  // Operand decode straight from the inputs; only used in the cycle start is accepted.
  logic [EXP_BIT-1:0] ea, eb;
  logic [MAN_BIT-1:0] ma, mb;
  logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, special, sgn;
  logic [N_BIT-1:0]   spec_res;
  logic signed [EW-1:0] e_init;

  assign ea      = a[N_BIT-2 -: EXP_BIT];
  assign eb      = b[N_BIT-2 -: EXP_BIT];
  assign ma      = a[MAN_BIT-1:0];
  assign mb      = b[MAN_BIT-1:0];
  assign a_nan   = (&ea) && (|ma);
  assign a_inf   = (&ea) && !(|ma);
  assign a_zero  = (ea == '0);
  assign b_nan   = (&eb) && (|mb);
  assign b_inf   = (&eb) && !(|mb);
  assign b_zero  = (eb == '0);
  assign special = a_nan | a_inf | a_zero | b_nan | b_inf | b_zero;
  assign sgn     = a[N_BIT-1] ^ b[N_BIT-1];
  assign e_init  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EW'(BIAS);

  always_comb begin
    spec_res = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = {sgn, {EXP_BIT{1'b1}}, 1'b1, {(MAN_BIT-1){1'b0}}};
    end else if (a_inf || b_zero) begin
      spec_res = {sgn, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
    end else begin
      spec_res = {sgn, {(N_BIT-1){1'b0}}};
    end
  end

  // One restoring-division step.
  logic          ge;
  logic [RW-1:0] r_sub, r_next;

  always_comb begin
    ge     = (r_q >= {1'b0, d_q});
    r_sub  = ge ? (r_q - {1'b0, d_q}) : r_q;
    r_next = r_sub << 1;
  end

  // Normalise, round to nearest even, then range-check the final exponent.
  logic [MAN_BIT-1:0]   frac;
  logic                 guard, sticky, rnd_up;
  logic [MAN_BIT:0]     frac_sum;
  logic signed [EW-1:0] e_adj, e_fin;
  logic [N_BIT-1:0]     rnd_res;

  always_comb begin
    if (q_q[QB-1]) begin
      frac   = q_q[QB-2:2];
      guard  = q_q[1];
      sticky = q_q[0] | (|r_q);
      e_adj  = e_q;
    end else begin
      frac   = q_q[QB-3:1];
      guard  = q_q[0];
      sticky = |r_q;
      e_adj  = e_q - $signed(EW'(1));
    end
    rnd_up   = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {{MAN_BIT{1'b0}}, rnd_up};
    // A carry out leaves the fraction wrapped to zero, which is the correct mantissa.
    e_fin    = e_adj + $signed({{(EW-1){1'b0}}, frac_sum[MAN_BIT]});
    rnd_res  = '0;
    if (e_fin >= EMAX) begin
      rnd_res = {sgn_q, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
    end else if (e_fin[EW-1] || (e_fin == '0)) begin
      rnd_res = {sgn_q, {(N_BIT-1){1'b0}}};
    end else begin
      rnd_res = {sgn_q, e_fin[EXP_BIT-1:0], frac_sum[MAN_BIT-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ready   <= 1'b1;
      out     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      e_q     <= '0;
      sgn_q   <= 1'b0;
      spec_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ready <= 1'b0;
            sgn_q <= sgn;
            if (special) begin
              spec_q  <= spec_res;
              state_q <= StSpec;
            end else begin
              r_q     <= {2'b01, ma};
              d_q     <= {1'b1, mb};
              q_q     <= '0;
              cnt_q   <= '0;
              e_q     <= e_init;
              state_q <= StDiv;
            end
          end
        end
        StSpec: begin
          out     <= spec_q;
          ready   <= 1'b1;
          state_q <= StIdle;
        end
        StDiv: begin
          r_q   <= r_next;
          q_q   <= {q_q[QB-2:0], ge};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(QB - 1)) begin
            state_q <= StRnd;
          end
        end
        StRnd: begin
          out     <= rnd_res;
          ready   <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
